pending_encoder: RTL

Parametrised, registered N-to-log2(N) encoder with event capture. It latches single-cycle request pulses into a pending set and emits one index per accepted transfer over a valid/ready handshake. Arbitration is fixed-priority or round-robin. It supersedes the purely combinational 8→3 encoder wherever request sources are pulsed or the consumer can stall, e.g. interrupt or button-event collection feeding a controller FSM.

---
 rtl/pending_encoder_pkg.sv | 13 +
 rtl/pending_encoder_if.sv | 29 ++
 rtl/pending_encoder_select.sv | 56 +++++
 rtl/pending_encoder.sv | 80 ++++++++
 4 files changed

// File: rtl/pending_encoder_pkg.sv
// Shared constants and helpers for the pending encoder slice.
package pending_encoder_pkg;

  // Selection modes understood by pe_select.
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Width of an index able to encode N request lines.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pending_encoder_if.sv
// Request / indexed-event handshake bundle between sources, encoder and consumer.
interface pending_encoder_if #(
  parameter int N = 8
) ();
  import pending_encoder_pkg::*;

  localparam int IDXW = idxWidth(N);

  logic [N-1:0]    req;
  logic [IDXW-1:0] idx;
  logic            valid;
  logic            ready;
  logic [N-1:0]    pending;
  logic            any;
  logic            overflow;

  // Encoder side.
  modport master (
    input  req, ready,
    output idx, valid, pending, any, overflow
  );

  // Request sources plus consumer side.
  modport slave (
    output req, ready,
    input  idx, valid, pending, any, overflow
  );

endinterface

// File: rtl/pending_encoder_select.sv
// Combinational selector: picks one set bit of pending, either the highest
// index (fixed priority) or the first at/above ptr+1 with wrap (round robin).
// Also usable on its own as the plain 8-to-3 priority encoder.
module pe_select #(
  parameter  int N    = 8,
  localparam int IDXW = pending_encoder_pkg::idxWidth(N)
) (
  input  logic [N-1:0]    pending,
  input  logic [IDXW-1:0] ptr,
  input  logic            mode,
  output logic            found,
  output logic [IDXW-1:0] index,
  output logic [N-1:0]    onehot
);
  import pending_encoder_pkg::*;

  logic            anySet;
  logic            upFound;
  logic [IDXW-1:0] topIdx;
  logic [IDXW-1:0] lowIdx;
  logic [IDXW-1:0] upIdx;

  // Scan for highest set bit, lowest set bit and lowest set bit above ptr.
  always_comb begin
    anySet  = 1'b0;
    upFound = 1'b0;
    topIdx  = '0;
    lowIdx  = '0;
    upIdx   = '0;
    // Ascending scan: the last hit is the highest index.
    for (int i = 0; i < N; i++) begin
      anySet = anySet | pending[i];
      topIdx = pending[i] ? IDXW'(i) : topIdx;
    end
    // Descending scan: the last hit is the lowest index (overall and above ptr).
    for (int i = N - 1; i >= 0; i--) begin
      lowIdx  = pending[i] ? IDXW'(i) : lowIdx;
      upFound = (pending[i] && (i > int'(ptr))) ? 1'b1 : upFound;
      upIdx   = (pending[i] && (i > int'(ptr))) ? IDXW'(i) : upIdx;
    end
  end

  // Choose per mode; round robin wraps to the lowest set bit when nothing lies above ptr.
  always_comb begin
    found = anySet;
    if (mode == MODE_RR) begin
      index = upFound ? upIdx : lowIdx;
    end else begin
      index = topIdx;
    end
    for (int i = 0; i < N; i++) begin
      onehot[i] = anySet && (index == IDXW'(i));
    end
  end

endmodule

// File: rtl/pending_encoder.sv
// Registered N-to-log2(N) encoder: captures request pulses into a pending set
// and hands one index per accepted transfer to the consumer.
module pending_encoder #(
  parameter int N           = 8,
  parameter int ROUND_ROBIN = 0
) (
  input logic              clk,
  input logic              reset,
  pending_encoder_if.master bus
);
  import pending_encoder_pkg::*;

  localparam int   IDXW = idxWidth(N);
  localparam logic MODE = (ROUND_ROBIN != 0) ? MODE_RR : MODE_FIXED;

  logic [N-1:0]    pendingR;
  logic [IDXW-1:0] idxR;
  logic            validR;
  logic            overflowR;
  logic [IDXW-1:0] ptrR;

  logic            selFound;
  logic [IDXW-1:0] selIdx;
  logic [N-1:0]    selOnehot;

  logic            load;
  logic [N-1:0]    take;
  logic [N-1:0]    pendingNext;
  logic            lost;

  pe_select #(.N(N)) uSelect (
    .pending (pendingR),
    .ptr     (ptrR),
    .mode    (MODE),
    .found   (selFound),
    .index   (selIdx),
    .onehot  (selOnehot)
  );

  // Decide this cycle's transfer, the next pending set and whether an event is lost.
  always_comb begin
    load        = !validR || bus.ready;
    take        = (load && selFound) ? selOnehot : '0;
    pendingNext = (pendingR & ~take) | bus.req;
    // A request on a bit still waiting (and not leaving now) cannot be stored twice.
    lost        = |(bus.req & pendingR & ~take);
  end

  // Pending, output, pointer and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pendingR  <= '0;
      idxR      <= '0;
      validR    <= 1'b0;
      overflowR <= 1'b0;
      ptrR      <= IDXW'(N - 1);
    end else begin
      pendingR  <= pendingNext;
      overflowR <= overflowR | lost;
      if (load) begin
        if (selFound) begin
          idxR   <= selIdx;
          validR <= 1'b1;
          ptrR   <= selIdx;
        end else begin
          validR <= 1'b0;
        end
      end else begin
        validR <= validR;
      end
    end
  end

  assign bus.idx      = idxR;
  assign bus.valid    = validR;
  assign bus.pending  = pendingR;
  assign bus.overflow = overflowR;
  assign bus.any      = (|pendingR) | validR;

endmodule
